tick_counter: RTL and testbench

// - Free-running N-bit event counter. Counts clock cycles in which a one-cycle
//   'tick' strobe is high, for example from a prescaler or a rate generator.
// - Wraps modulo 2^N and flags the wrap on 'of' so that a downstream block can

---
 rtl/tick_counter.sv | 53 +++++
 tb/tb_tick_counter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// Free-running N-bit tick counter with wrap flag; define TICK_COUNTER_STICKY_OF_EN
// to make the overflow flag sticky with an of_clr input.
module tick_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
`ifdef TICK_COUNTER_STICKY_OF_EN
    input  logic         of_clr,
`endif
    output logic [N-1:0] counter,
    output logic         of
);

    logic [N-1:0] counter_q, counter_d;
    logic         of_q, of_d;
    logic         wrap;

    assign wrap = tick && (counter_q == {N{1'b1}});

    always_comb begin
        counter_d = counter_q;
        if (tick) begin
            counter_d = counter_q + N'(1);
        end
    end

`ifdef TICK_COUNTER_STICKY_OF_EN
    // A wrap on the same edge as a clear takes priority so no overflow is lost.
    always_comb begin
        of_d = wrap | (of_q & ~of_clr);
    end
`else
    always_comb begin
        of_d = wrap;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            of_q      <= 1'b0;
        end else begin
            counter_q <= counter_d;
            of_q      <= of_d;
        end
    end

    assign counter = counter_q;
    assign of      = of_q;

endmodule

// File: tb/tb_tick_counter.sv
// Scoreboard bench for tick_counter (N=4): stimulus pushes expected {counter, of},
// a monitor pops and compares whenever the outputs are sampled.
module tb_tick_counter;

`ifdef TICK_COUNTER_STICKY_OF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       of_clr = 1'b0;
    logic [3:0] counter;
    logic       of;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    bit sticky_exp = 1'b0;
    event sample_ev;

    tick_counter #(.N(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
`ifdef TICK_COUNTER_STICKY_OF_EN
        .of_clr  (of_clr),
`endif
        .counter (counter),
        .of      (of)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the falling edge, or on demand after an async event.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({counter, of} !== e) begin
                    errors++;
                    $display("FAIL chk%0d @%0t: counter=%0d of=%0b, expected counter=%0d of=%0b",
                             checks, $time, counter, of, e[4:1], e[0]);
                end
            end
        end
    end

    // exp_of is the pulse-mode value; the sticky build derives its own expectation from it.
    task automatic step(input logic r, input logic t, input logic c,
                        input logic [3:0] exp_cnt, input logic exp_of);
        logic eo;
        @(negedge clk);
        reset  = r;
        tick   = t;
        of_clr = c;
        @(posedge clk);
        if (r)           sticky_exp = 1'b0;
        else if (exp_of) sticky_exp = 1'b1;
        else if (c)      sticky_exp = 1'b0;
        eo = STICKY ? sticky_exp : exp_of;
        exp_q.push_back({exp_cnt, eo});
    endtask

    task automatic async_reset();
        @(negedge clk);
        tick = 1'b1;
        #2 reset = 1'b1;
        sticky_exp = 1'b0;
        #1 exp_q.push_back({4'd0, 1'b0});
        -> sample_ev;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        reset = 1'b1;
        #1 exp_q.push_back({4'd0, 1'b0});
        -> sample_ev;

        // tick ignored while reset held
        repeat (3) step(1, 1, 0, 4'd0, 1'b0);

        // single ticks: 1, then 2, then 5; first edge after release counts
        step(0, 1, 0, 4'd1, 1'b0);
        step(0, 0, 0, 4'd1, 1'b0);
        step(0, 0, 0, 4'd1, 1'b0);
        step(0, 1, 0, 4'd2, 1'b0);
        step(0, 1, 0, 4'd3, 1'b0);
        step(0, 0, 0, 4'd3, 1'b0);
        step(0, 1, 0, 4'd4, 1'b0);
        step(0, 1, 0, 4'd5, 1'b0);
        step(0, 1, 0, 4'd6, 1'b0);
        step(0, 1, 0, 4'd7, 1'b0);
        step(0, 1, 0, 4'd8, 1'b0);
        step(0, 0, 0, 4'd8, 1'b0);

        // overflow: 14 ticks from 8, wrap on the 8th
        for (int i = 1; i <= 14; i++) begin
            v = 8 + i;
            step(0, 1, 0, 4'(v % 16), (v == 16));
        end
        step(0, 0, 0, 4'd6, 1'b0);

        // climb to 11, then reset asynchronously during a tick
        step(0, 1, 0, 4'd7, 1'b0);
        step(0, 1, 0, 4'd8, 1'b0);
        step(0, 1, 0, 4'd9, 1'b0);
        step(0, 1, 0, 4'd10, 1'b0);
        step(0, 1, 0, 4'd11, 1'b0);
        async_reset();
        step(1, 1, 0, 4'd0, 1'b0);
        step(1, 1, 0, 4'd0, 1'b0);
        step(0, 1, 0, 4'd1, 1'b0);
        step(0, 1, 0, 4'd2, 1'b0);
        step(0, 1, 0, 4'd3, 1'b0);
        step(0, 0, 0, 4'd3, 1'b0);

        // continuous tick for 32 edges from 0: two of pulses 16 edges apart
        async_reset();
        step(1, 0, 0, 4'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step(0, 1, 0, 4'(i % 16), (i % 16 == 0));
        end
        step(0, 0, 0, 4'd0, 1'b0);

`ifdef TICK_COUNTER_STICKY_OF_EN
        step(0, 0, 1, 4'd0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 4'(i % 16), (i == 16));
        end
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 4'(i), 1'b0);
        step(0, 0, 1, 4'd5, 1'b0);
        for (int i = 6; i <= 15; i++) step(0, 1, 0, 4'(i), 1'b0);
        step(0, 1, 1, 4'd0, 1'b1);
        step(0, 0, 0, 4'd0, 1'b0);
`endif

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
